// File: rtl/code_mux_arbiter.sv
// Round-robin arbiter/sequencer in front of the four-input 8-bit code mux.
// Drives the mux select/enable, inserts a one-cycle settling gap between grants, and registers the routed code.
module code_mux_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [3:0] i_req,
  input  logic [7:0] i_code_0,
  input  logic [7:0] i_code_1,
  input  logic [7:0] i_code_2,
  input  logic [7:0] i_code_3,
  output logic [3:0] o_grant,
  output logic [1:0] o_sel_code,
  output logic       o_en,
  output logic [7:0] o_code,
  output logic       o_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  logic [1:0] last;
  logic [7:0] cnt;
  logic [1:0] next_idx;
  logic [7:0] code_sel;
  logic       release_now;
  logic       start_grant;

  // Walk the search order backwards so the nearest requester after `last` wins.
  always_comb begin
    // NOTE: assign every always_comb output a default first; a path that skips it infers a latch.
    next_idx = last;
    for (int i = 3; i >= 1; i--) begin
      if (i_req[last + 2'(i)]) next_idx = last + 2'(i);
    end
  end

  always_comb begin
    code_sel = i_code_0;
    case (o_sel_code)
      2'd0:    code_sel = i_code_0;
      2'd1:    code_sel = i_code_1;
      2'd2:    code_sel = i_code_2;
      default: code_sel = i_code_3;
    endcase
  end

  assign start_grant = i_en && (|i_req);
  assign release_now = !i_req[o_sel_code] || !i_en || (cnt == HOLD_LAST);

  // NOTE: all state here is sequential, so every assignment is non-blocking to avoid ordering races.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last       <= 2'd3;
      cnt        <= 8'd0;
      o_grant    <= 4'b0000;
      o_sel_code <= 2'd0;
      o_en       <= 1'b0;
      o_code     <= 8'h00;
      o_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          o_valid <= 1'b0;
          if (start_grant) begin
            state      <= GRANT;
            cnt        <= 8'd0;
            o_grant    <= 4'b0001 << next_idx;
            o_sel_code <= next_idx;
            o_en       <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          o_code  <= code_sel;
          o_valid <= 1'b1;
          if (release_now) begin
            state   <= GAP;
            last    <= o_sel_code;
            cnt     <= 8'd0;
            o_grant <= 4'b0000;
            o_en    <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          o_grant <= 4'b0000;
          o_en    <= 1'b0;
          o_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_mux_arbiter.sv
// Scoreboard bench for code_mux_arbiter: directed phases queue expected grants and codes,
// a negedge monitor pops and compares whenever o_en or o_valid is presented.
module tb_code_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] req;
  logic [7:0] code_0, code_1, code_2, code_3;
  logic [3:0] grant;
  logic [1:0] sel_code;
  logic       mux_en;
  logic [7:0] code;
  logic       valid;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  int         exp_grant[$];
  logic [7:0] exp_code[$];

  always #5 clk = ~clk;

  code_mux_arbiter #(.HOLD_CYCLES(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_req      (req),
    .i_code_0   (code_0),
    .i_code_1   (code_1),
    .i_code_2   (code_2),
    .i_code_3   (code_3),
    .o_grant    (grant),
    .o_sel_code (sel_code),
    .o_en       (mux_en),
    .o_code     (code),
    .o_valid    (valid)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_grants(input int g, input int n);
    repeat (n) exp_grant.push_back(g);
  endtask

  task automatic push_codes(input logic [7:0] c, input int n);
    repeat (n) exp_code.push_back(c);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      check("onehot_en", {31'd0, (grant == 4'b0000 || $onehot(grant)) && (mux_en == (grant != 4'b0000))}, 32'd1);
      if (mux_en) begin
        if (exp_grant.size() == 0) begin
          check("unexpected_grant", {28'd0, grant}, 32'd0);
        end else begin
          int g;
          g = exp_grant.pop_front();
          check("grant", {28'd0, grant}, 32'd1 << g);
          check("sel_code", {30'd0, sel_code}, g);
        end
      end
      if (valid) begin
        if (exp_code.size() == 0) begin
          check("unexpected_valid", {24'd0, code}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] c;
          c = exp_code.pop_front();
          check("code", {24'd0, code}, {24'd0, c});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; req = 4'b1111;
    code_0 = 8'h80; code_1 = 8'h40; code_2 = 8'hC0; code_3 = 8'h20;

    // Reset held for three edges with every request pending.
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("reset_outputs", {17'd0, grant, sel_code, mux_en, code, valid}, 32'd0);
      mon_on = 1'b1;
    end

    // Single persistent requester 0: 4 grant cycles, 1 gap, repeating.
    push_grants(0, 8);
    push_codes(8'h80, 8);
    rst = 1'b0; req = 4'b0001;
    step(5);
    check("gap_grant_zero", {28'd0, grant}, 32'd0);
    check("gap_sel_held", {30'd0, sel_code}, 32'd0);
    step(5);

    // Full load: round robin 1,2,3,0.
    push_grants(1, 4); push_grants(2, 4); push_grants(3, 4); push_grants(0, 4);
    push_codes(8'h40, 4); push_codes(8'hC0, 4); push_codes(8'h20, 4); push_codes(8'h80, 4);
    req = 4'b1111;
    step(20);

    // Requester 1 drops after two grant cycles; requester 2 follows after the gap.
    push_grants(1, 2); push_codes(8'h40, 2);
    req = 4'b1110;
    step(2);
    req = 4'b1100;
    step(1);
    check("drop_gap_grant", {28'd0, grant}, 32'd0);
    check("drop_gap_sel", {30'd0, sel_code}, 32'd1);

    // Enable dropped during requester 2's grant, then re-raised: requester 3 first.
    push_grants(2, 2); push_codes(8'hC0, 2);
    step(1);
    check("grant_after_drop", {28'd0, grant}, 32'b0100);
    step(1);
    en = 1'b0;
    step(3);
    check("idle_en_low", {31'd0, mux_en}, 32'd0);
    check("idle_sel_held", {30'd0, sel_code}, 32'd2);
    check("idle_valid_low", {31'd0, valid}, 32'd0);
    step(2);
    push_grants(3, 4); push_codes(8'h20, 4);
    en = 1'b1;
    step(5);

    // Reset during the third cycle of a grant to requester 1.
    push_grants(1, 3); push_codes(8'h40, 2);
    req = 4'b0010;
    step(3);
    rst = 1'b1;
    step(1);
    check("midgrant_reset", {17'd0, grant, sel_code, mux_en, code, valid}, 32'd0);

    // First post-reset grant goes to requester 0.
    push_grants(0, 4); push_codes(8'h80, 4);
    rst = 1'b0; req = 4'b1111;
    step(1);
    check("post_reset_grant", {28'd0, grant}, 32'b0001);
    step(4);
    req = 4'b0000;
    step(4);

    check("grant_queue_empty", exp_grant.size(), 32'd0);
    check("code_queue_empty", exp_code.size(), 32'd0);
    mon_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
